// File: rtl/uart_cmd_decoder.sv
// UART command front-end: deserialises 8N1 bytes into 32-bit words and decodes
// reset / program-mode commands, streaming other words into instruction memory.
module uart_cmd_decoder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              cpu_reset_out,
    output logic              prog_mode_out,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              word_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CLKS) + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0]  TMO_M1   = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [31:0] CMD_RST1 = 32'h3154_5352;
    localparam logic [31:0] CMD_RST0 = 32'h3054_5352;
    localparam logic [31:0] CMD_IME1 = 32'h3145_4D49;
    localparam logic [31:0] CMD_IME0 = 32'h3045_4D49;

    logic              rx_meta_q, rx_sync_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_ok_s, stop_bad_s;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              word_valid_q, word_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              rst_hold_q, rst_hold_d;
    logic              prog_mode_q, prog_mode_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver FSM: half-bit start check, then mid-bit sampling of data and stop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = ST_START;
                else            state_d = ST_IDLE;
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    if (!rx_sync_q) state_d = ST_DATA;
                    else            state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_sync_q) byte_ok_s  = 1'b1;
                    else           stop_bad_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Word assembly, LSB byte first, with idle timeout discarding partial words.
    always_comb begin
        idx_d        = idx_q;
        word_d       = word_q;
        tmo_d        = tmo_q;
        word_valid_d = 1'b0;
        frame_err_d  = stop_bad_s;
        if (stop_bad_s) begin
            idx_d = 2'd0;
            tmo_d = '0;
        end else if (byte_ok_s) begin
            word_d[{idx_q, 3'b000} +: 8] = shift_q;
            idx_d        = idx_q + 2'd1;
            word_valid_d = (idx_q == 2'd3);
            tmo_d        = '0;
        end else if (idx_q != 2'd0) begin
            if (tmo_q == TMO_M1) begin
                idx_d = 2'd0;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Decode the completed word one cycle after assembly; commands are never written.
    always_comb begin
        rst_hold_d  = rst_hold_q;
        prog_mode_d = prog_mode_q;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        im_we_d     = 1'b0;
        if (im_we_q) begin
            im_addr_d = im_addr_q + ADDR_ONE;
        end else begin
            im_addr_d = im_addr_q;
        end
        if (word_valid_q) begin
            case (word_q)
                CMD_RST1: rst_hold_d = 1'b1;
                CMD_RST0: rst_hold_d = 1'b0;
                CMD_IME1: begin
                    prog_mode_d = 1'b1;
                    im_addr_d   = '0;
                end
                CMD_IME0: prog_mode_d = 1'b0;
                default: begin
                    if (prog_mode_q) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = word_q;
                    end else begin
                        im_we_d = 1'b0;
                    end
                end
            endcase
        end else begin
            im_we_d = 1'b0;
        end
        cpu_reset_d = rst_hold_d | prog_mode_d;
    end

    // State registers for receiver, assembler and decoder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            idx_q        <= 2'd0;
            word_q       <= 32'h0000_0000;
            tmo_q        <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rst_hold_q   <= 1'b0;
            prog_mode_q  <= 1'b0;
            cpu_reset_q  <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            rst_hold_q   <= rst_hold_d;
            prog_mode_q  <= prog_mode_d;
            cpu_reset_q  <= cpu_reset_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
        end
    end

    assign cpu_reset_out = cpu_reset_q;
    assign prog_mode_out = prog_mode_q;
    assign im_we         = im_we_q;
    assign im_addr       = im_addr_q;
    assign im_wdata      = im_wdata_q;
    assign word_valid    = word_valid_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder, scaled to a short bit time and 2-bit address.
module tb_uart_cmd_decoder;

    localparam int CPB    = 16;
    localparam int TMO    = 1600;
    localparam int AW     = 2;

    localparam logic [31:0] RST1 = 32'h3154_5352;
    localparam logic [31:0] RST0 = 32'h3054_5352;
    localparam logic [31:0] IME1 = 32'h3145_4D49;
    localparam logic [31:0] IME0 = 32'h3045_4D49;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          cpu_reset_out, prog_mode_out, im_we, word_valid, frame_err;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;

    int checks = 0;
    int failures = 0;

    int cyc = 0, wv_cyc = -10, wv_cnt = 0, we_cnt = 0, fe_cnt = 0;
    int seq_err = 0, cr_err = 0;
    logic prev_we = 1'b0, prev_cr = 1'b0;
    logic [AW-1:0] we_addr_q[$];
    logic [31:0]   we_data_q[$];

    uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .cpu_reset_out(cpu_reset_out), .prog_mode_out(prog_mode_out),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .word_valid(word_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Output monitor: counts pulses, logs writes, checks pulse-to-pulse timing.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (word_valid) begin
            wv_cnt = wv_cnt + 1;
            wv_cyc = cyc;
        end
        if (im_we) begin
            we_cnt = we_cnt + 1;
            we_addr_q.push_back(im_addr);
            we_data_q.push_back(im_wdata);
            if (cyc != wv_cyc + 1 || prev_we) seq_err = seq_err + 1;
        end
        prev_we = im_we;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (cpu_reset_out !== prev_cr && reset === 1'b1 && cyc != wv_cyc + 1) cr_err = cr_err + 1;
        prev_cr = cpu_reset_out;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
        step(4);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx = 1'b1;
        step(5);
        checks++; if (cpu_reset_out !== 1'b0) begin failures++; $display("FAIL reset_cpu_reset got=%b exp=0", cpu_reset_out); end
        checks++; if (prog_mode_out !== 1'b0) begin failures++; $display("FAIL reset_prog_mode got=%b exp=0", prog_mode_out); end
        checks++; if (im_we !== 1'b0) begin failures++; $display("FAIL reset_im_we got=%b exp=0", im_we); end
        checks++; if (im_addr !== 2'd0) begin failures++; $display("FAIL reset_im_addr got=%0d exp=0", im_addr); end
        checks++; if (im_wdata !== 32'h0) begin failures++; $display("FAIL reset_im_wdata got=%h exp=0", im_wdata); end
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        reset = 1'b1;
        step(4);
    endtask

    task automatic test_rst_cmds;
        int wv0, we0;
        wv0 = wv_cnt; we0 = we_cnt;
        send_word(RST1);
        checks++; if (cpu_reset_out !== 1'b1) begin failures++; $display("FAIL rst1_cpu_reset got=%b exp=1", cpu_reset_out); end
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL rst1_word_valid got=%0d exp=1", wv_cnt - wv0); end
        checks++; if (we_cnt != we0) begin failures++; $display("FAIL rst1_no_write got=%0d exp=0", we_cnt - we0); end
        send_word(RST0);
        checks++; if (cpu_reset_out !== 1'b0) begin failures++; $display("FAIL rst0_cpu_reset got=%b exp=0", cpu_reset_out); end
        checks++; if (wv_cnt - wv0 != 2) begin failures++; $display("FAIL rst0_word_valid got=%0d exp=2", wv_cnt - wv0); end
    endtask

    task automatic test_data_outside;
        int wv0, we0;
        wv0 = wv_cnt; we0 = we_cnt;
        send_word(32'h3030_3030);
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL data_word_valid got=%0d exp=1", wv_cnt - wv0); end
        checks++; if (we_cnt != we0) begin failures++; $display("FAIL data_no_write got=%0d exp=0", we_cnt - we0); end
        checks++; if (im_addr !== 2'd0) begin failures++; $display("FAIL data_im_addr got=%0d exp=0", im_addr); end
    endtask

    task automatic test_program_load;
        int n0;
        n0 = we_addr_q.size();
        send_word(IME1);
        checks++; if (prog_mode_out !== 1'b1) begin failures++; $display("FAIL ime1_prog_mode got=%b exp=1", prog_mode_out); end
        checks++; if (cpu_reset_out !== 1'b1) begin failures++; $display("FAIL ime1_cpu_reset got=%b exp=1", cpu_reset_out); end
        send_word(32'h2008_0005);
        send_word(32'h8C09_0004);
        checks++; if (we_addr_q.size() != n0 + 2) begin failures++; $display("FAIL load_write_count got=%0d exp=2", we_addr_q.size() - n0); end
        else begin
            checks++; if (we_addr_q[n0] !== 2'd0 || we_data_q[n0] !== 32'h2008_0005) begin failures++; $display("FAIL load_write0 got=%0d:%h exp=0:20080005", we_addr_q[n0], we_data_q[n0]); end
            checks++; if (we_addr_q[n0+1] !== 2'd1 || we_data_q[n0+1] !== 32'h8C09_0004) begin failures++; $display("FAIL load_write1 got=%0d:%h exp=1:8c090004", we_addr_q[n0+1], we_data_q[n0+1]); end
        end
        send_word(IME0);
        checks++; if (prog_mode_out !== 1'b0) begin failures++; $display("FAIL ime0_prog_mode got=%b exp=0", prog_mode_out); end
        checks++; if (im_addr !== 2'd2) begin failures++; $display("FAIL ime0_im_addr got=%0d exp=2", im_addr); end
        checks++; if (cpu_reset_out !== 1'b0) begin failures++; $display("FAIL ime0_cpu_reset got=%b exp=0", cpu_reset_out); end
    endtask

    task automatic test_bad_stop;
        int fe0, wv0;
        fe0 = fe_cnt; wv0 = wv_cnt;
        send_byte(8'h52, 1'b0);
        step(2 * CPB);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL badstop_frame_err got=%0d exp=1", fe_cnt - fe0); end
        send_word(RST1);
        checks++; if (cpu_reset_out !== 1'b1) begin failures++; $display("FAIL badstop_rst1 got=%b exp=1", cpu_reset_out); end
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL badstop_word_valid got=%0d exp=1", wv_cnt - wv0); end
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL badstop_fe_once got=%0d exp=1", fe_cnt - fe0); end
    endtask

    task automatic test_glitch;
        int wv0, fe0;
        send_word(RST0);
        checks++; if (cpu_reset_out !== 1'b0) begin failures++; $display("FAIL glitch_pre_rst0 got=%b exp=0", cpu_reset_out); end
        wv0 = wv_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2 * CPB);
        send_word(RST1);
        checks++; if (cpu_reset_out !== 1'b1) begin failures++; $display("FAIL glitch_rst1 got=%b exp=1", cpu_reset_out); end
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL glitch_word_valid got=%0d exp=1", wv_cnt - wv0); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt - fe0); end
    endtask

    task automatic test_timeout;
        int wv0;
        send_word(RST0);
        wv0 = wv_cnt;
        send_byte(8'h52, 1'b1);
        send_byte(8'h53, 1'b1);
        step(TMO);
        send_word(RST1);
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL timeout_word_valid got=%0d exp=1", wv_cnt - wv0); end
        checks++; if (cpu_reset_out !== 1'b1) begin failures++; $display("FAIL timeout_rst1 got=%b exp=1", cpu_reset_out); end
    endtask

    task automatic test_reset_mid;
        int wv0;
        send_word(IME1);
        send_word(32'hDEAD_BEEF);
        checks++; if (im_addr !== 2'd1) begin failures++; $display("FAIL mid_pre_addr got=%0d exp=1", im_addr); end
        rx = 1'b0;
        step(CPB);
        rx = 1'b1;
        step(2 * CPB);
        reset = 1'b0;
        step(3);
        checks++; if ({cpu_reset_out, prog_mode_out, im_we, word_valid, frame_err} !== 5'b0) begin failures++; $display("FAIL mid_ctrl_outputs got=%b exp=00000", {cpu_reset_out, prog_mode_out, im_we, word_valid, frame_err}); end
        checks++; if (im_addr !== 2'd0 || im_wdata !== 32'h0) begin failures++; $display("FAIL mid_mem_outputs got=%0d:%h exp=0:0", im_addr, im_wdata); end
        rx = 1'b1;
        step(2);
        reset = 1'b1;
        step(2 * CPB);
        wv0 = wv_cnt;
        send_word(RST1);
        checks++; if (cpu_reset_out !== 1'b1 || prog_mode_out !== 1'b0) begin failures++; $display("FAIL mid_post_rst1 got=%b%b exp=10", cpu_reset_out, prog_mode_out); end
        checks++; if (wv_cnt - wv0 != 1) begin failures++; $display("FAIL mid_word_valid got=%0d exp=1", wv_cnt - wv0); end
        send_word(RST0);
    endtask

    task automatic test_wrap;
        int n0;
        logic [AW-1:0] exp_a;
        n0 = we_addr_q.size();
        send_word(IME1);
        for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i));
        checks++; if (we_addr_q.size() != n0 + 5) begin failures++; $display("FAIL wrap_write_count got=%0d exp=5", we_addr_q.size() - n0); end
        else begin
            for (int i = 0; i < 5; i++) begin
                exp_a = AW'(i);
                checks++;
                if (we_addr_q[n0+i] !== exp_a || we_data_q[n0+i] !== 32'hA000_0000 + 32'(i)) begin
                    failures++;
                    $display("FAIL wrap_write%0d got=%0d:%h exp=%0d:%h", i, we_addr_q[n0+i], we_data_q[n0+i], exp_a, 32'hA000_0000 + 32'(i));
                end
            end
        end
        send_word(IME0);
        checks++; if (im_addr !== 2'd1 || prog_mode_out !== 1'b0) begin failures++; $display("FAIL wrap_after_ime0 got=%0d:%b exp=1:0", im_addr, prog_mode_out); end
    endtask

    task automatic test_timing;
        checks++; if (seq_err != 0) begin failures++; $display("FAIL im_we_timing got=%0d exp=0", seq_err); end
        checks++; if (cr_err != 0) begin failures++; $display("FAIL cpu_reset_timing got=%0d exp=0", cr_err); end
    endtask

    initial begin
        test_reset();
        test_rst_cmds();
        test_data_outside();
        test_program_load();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Serial command front-end of the MIPS debug top level. It deserialises 8N1 UART bytes on `rx` and assembles each group of four bytes, LSB first, into a 32-bit word. Command words control CPU reset and program mode. All other words received while in program mode are written sequentially into instruction memory. It sits between the board `rx` pin and the CPU core, instruction memory and debugger display logic.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud)
- ADDR_W, 8, instruction-memory word-address width
- TIMEOUT_CLKS, 43400, idle clocks after which a partial word is discarded (10 byte times)

- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx  in  1  UART serial input; idles high
- cpu_reset_out  out  1  1 = CPU held in reset
- prog_mode_out  out  1  1 = instruction-memory program mode active
- im_we  out  1  one-cycle instruction-memory write strobe
- im_addr  out  ADDR_W  word address for im_we
- im_wdata  out  32  word for im_we
- word_valid  out  1  one-cycle pulse per assembled word, including commands
- frame_err  out  1  one-cycle pulse on a bad stop bit

## Operation
- rx passes through a 2-flop synchroniser; the flops reset to 1. All logic uses the synchronised rx.
- Receiver FSM states are IDLE, START, DATA, STOP.
  - IDLE → START on synchronised rx = 0.
  - START waits CLKS_PER_BIT/2 cycles, then resamples. If rx = 0, go to DATA. If rx = 1, the low was a glitch: return to IDLE with no output.
  - DATA samples 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - STOP samples one bit after CLKS_PER_BIT. If it is 1, the byte is accepted. If it is 0, frame_err pulses, the byte is dropped and the byte index clears to 0. STOP then returns to IDLE.
- Word assembly: accepted byte k (k = 0..3) goes to word[8k+7:8k]. After byte 3 the word is complete and the index returns to 0.
- Timeout: if the index is nonzero and no byte is accepted for TIMEOUT_CLKS cycles, the index clears to 0 and the partial word is discarded.
- Word decode happens the cycle after completion:
  - 0x31545352 "RST1": rst_hold ← 1.
  - 0x30545352 "RST0": rst_hold ← 0.
  - 0x31454D49 "IME1": prog_mode ← 1 and im_addr ← 0. Re-entering while already in program mode also resets im_addr to 0.
  - 0x30454D49 "IME0": prog_mode ← 0. im_addr holds its value.
  - Any other word with prog_mode = 1: im_we pulses, im_wdata = word, im_addr = current address. The address increments the cycle after the write.
  - Any other word with prog_mode = 0: discarded, but word_valid still pulses.
- Command words are never written to memory. As a consequence, an instruction equal to one of the four command codes cannot be loaded.
- im_addr wraps from 2^ADDR_W−1 to 0 without a flag.
- cpu_reset_out = rst_hold OR prog_mode, so the CPU is held in reset for the whole of program mode.
- Mid-operation reset (reset low): asynchronous return to IDLE, index = 0, all state cleared.

## Timing
- Reset values: cpu_reset_out 0, prog_mode_out 0, im_we 0, im_addr 0, im_wdata 0, word_valid 0, frame_err 0.
- One frame is 10 × CLKS_PER_BIT = 4340 cycles at the default; the receiver is ready for the next start bit after the stop-bit sample.
- Stop-bit sample cycle = S. Between the rx falling edge and S there are 2 synchroniser cycles plus 9.5 × CLKS_PER_BIT.
- word_valid, im_we and frame_err are all registered. Relative to the S of the relevant byte:
  - word_valid: S+1 for byte 3.
  - im_we: S+2 for byte 3.
  - frame_err: S+1 for the failing byte.
- Command words update rst_hold and prog_mode at S+2, the same cycle im_we would assert.
- Consecutive words are at least 4 frames apart, so no back-pressure is needed; im_we is never asserted on consecutive cycles.

## Test plan
- **RST1 / RST0:** send RST1 (bytes 52 53 54 31). cpu_reset_out rises at S+2; word_valid pulses once; im_we stays 0. Send RST0; cpu_reset_out returns to 0.
- **Data outside program mode:** send 0x30303030 with prog_mode 0. word_valid pulses; no im_we; im_addr stays 0.
- **Program load:** send IME1, then 0x20080005, 0x8C090004, then IME0.
  - prog_mode_out goes 1 and cpu_reset_out goes 1.
  - im_we pulses at addr 0 with 0x20080005, then at addr 1 with 0x8C090004.
  - After IME0: prog_mode_out = 0, im_addr = 2, cpu_reset_out = 0.
- **Bad stop bit:** send byte 0x52 with stop bit 0, then a full RST1. frame_err pulses once; the following RST1 still decodes correctly.
- **Glitch and timeout:**
  - A 100-cycle low pulse on rx produces no byte.
  - Send 2 bytes, idle for 43400 cycles, then send 4 bytes of RST1. Exactly one word_valid, and cpu_reset_out = 1.
- **Reset mid-frame and address wrap:**
  - Assert reset during DATA; all outputs return to reset values and the next full word decodes correctly.
  - With ADDR_W=2, 5 data words in program mode produce writes at addresses 0,1,2,3,0.
